// File: rtl/rv32i_multicycle_ctrl_if.sv
// Memory handshake bundle between the RV32I multi-cycle controller and the
// instruction/data memories.
interface rv32i_multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// write-back on a shared datapath, with a sticky trap for bad opcodes and memory timeouts.
module rv32i_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    rv32i_multicycle_ctrl_if.master mem,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic                   br_taken,
    output logic                   ir_we,
    output logic                   alu_out_we,
    output logic                   pc_we,
    output logic [1:0]             pc_sel,
    output logic                   alu_a_sel,
    output logic                   alu_b_sel,
    output logic                   rf_we,
    output logic [1:0]             wb_sel,
    output logic                   instret,
    output logic                   trap,
    output logic [2:0]             state
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);
    localparam bit TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [6:0]          op_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                trap_q;
    logic                waiting;
    logic                limit_hit;
    logic                funct3_unused;

    // funct3 is consumed by the datapath only
    assign funct3_unused = ^funct3;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    assign waiting   = ((state_q == FETCH) && !mem.imem_ready) ||
                       ((state_q == MEM)   && !mem.dmem_ready);
    assign limit_hit = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

    // State, captured opcode, wait counter and sticky trap
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= opcode;
            end
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (waiting && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (state_d == HALT) begin
                trap_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem.imem_ready)  state_d = DECODE;
                else if (limit_hit)  state_d = HALT;
            end
            DECODE: state_d = is_legal(opcode) ? EXEC : HALT;
            EXEC: begin
                case (op_q)
                    OP_LOAD, OP_STORE: state_d = MEM;
                    OP_BRANCH:         state_d = FETCH;
                    default:           state_d = WB;
                endcase
            end
            MEM: begin
                if (mem.dmem_ready)  state_d = (op_q == OP_STORE) ? FETCH : WB;
                else if (limit_hit)  state_d = HALT;
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Strobes and selects; everything is forced low while rst is high
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        alu_out_we   = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        instret      = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem.imem_req = 1'b1;
                    ir_we        = mem.imem_ready;
                end
                EXEC: begin
                    alu_out_we = 1'b1;
                    case (op_q)
                        OP_I, OP_JALR, OP_LOAD, OP_STORE: alu_b_sel = 1'b1;
                        OP_AUIPC: begin
                            alu_a_sel = 1'b1;
                            alu_b_sel = 1'b1;
                        end
                        OP_BRANCH: begin
                            pc_we   = 1'b1;
                            pc_sel  = br_taken ? 2'd1 : 2'd0;
                            instret = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = (op_q == OP_STORE);
                    if (mem.dmem_ready && (op_q == OP_STORE)) begin
                        pc_we   = 1'b1;
                        instret = 1'b1;
                    end
                end
                WB: begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    instret = 1'b1;
                    case (op_q)
                        OP_LOAD:          wb_sel = 2'd1;
                        OP_JAL, OP_JALR:  wb_sel = 2'd2;
                        OP_LUI:           wb_sel = 2'd3;
                        default:          wb_sel = 2'd0;
                    endcase
                    case (op_q)
                        OP_JAL:  pc_sel = 2'd1;
                        OP_JALR: pc_sel = 2'd2;
                        default: pc_sel = 2'd0;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign trap  = trap_q;
    assign state = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench for rv32i_multicycle_ctrl: per-cycle expected outputs are queued
// with their stimulus, then replayed and compared against the DUT.
module tb_rv32i_multicycle_ctrl;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam int T_LIMIT = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       alu_out_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       a_sel;
        logic       b_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       instret;
        logic       trap;
    } obs_t;

    typedef struct {
        logic       im;
        logic       dm;
        logic [6:0] op;
        logic       br;
        obs_t       exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken;

    logic       ir_we, alu_out_we, pc_we, alu_a_sel, alu_b_sel, rf_we, instret, trap;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;
    logic       ir_we_t, alu_out_we_t, pc_we_t, alu_a_sel_t, alu_b_sel_t, rf_we_t, instret_t, trap_t;
    logic [1:0] pc_sel_t, wb_sel_t;
    logic [2:0] state_t;

    cyc_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv32i_multicycle_ctrl_if mif ();
    rv32i_multicycle_ctrl_if mif_t ();

    rv32i_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .mem(mif), .opcode(opcode), .funct3(funct3),
        .br_taken(br_taken), .ir_we(ir_we), .alu_out_we(alu_out_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .instret(instret), .trap(trap), .state(state)
    );

    rv32i_multicycle_ctrl #(.MEM_WAIT_MAX(T_LIMIT)) dut_t (
        .clk(clk), .rst(rst), .mem(mif_t), .opcode(opcode), .funct3(funct3),
        .br_taken(br_taken), .ir_we(ir_we_t), .alu_out_we(alu_out_we_t), .pc_we(pc_we_t),
        .pc_sel(pc_sel_t), .alu_a_sel(alu_a_sel_t), .alu_b_sel(alu_b_sel_t), .rf_we(rf_we_t),
        .wb_sel(wb_sel_t), .instret(instret_t), .trap(trap_t), .state(state_t)
    );

    function automatic obs_t get_obs(input bit which);
        obs_t o;
        if (which) begin
            o = '{st: state_t, imem_req: mif_t.imem_req, dmem_req: mif_t.dmem_req,
                  dmem_we: mif_t.dmem_we, ir_we: ir_we_t, alu_out_we: alu_out_we_t,
                  pc_we: pc_we_t, pc_sel: pc_sel_t, a_sel: alu_a_sel_t, b_sel: alu_b_sel_t,
                  rf_we: rf_we_t, wb_sel: wb_sel_t, instret: instret_t, trap: trap_t};
        end else begin
            o = '{st: state, imem_req: mif.imem_req, dmem_req: mif.dmem_req,
                  dmem_we: mif.dmem_we, ir_we: ir_we, alu_out_we: alu_out_we,
                  pc_we: pc_we, pc_sel: pc_sel, a_sel: alu_a_sel, b_sel: alu_b_sel,
                  rf_we: rf_we, wb_sel: wb_sel, instret: instret, trap: trap};
        end
        return o;
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    task automatic push(input logic im, input logic dm, input logic [6:0] op,
                        input logic br, input obs_t e);
        cyc_t c;
        c.im = im; c.dm = dm; c.op = op; c.br = br; c.exp = e;
        sb.push_back(c);
    endtask

    task automatic push_fetch(input logic [6:0] op, input int iw);
        obs_t o;
        o = blank(3'd0);
        o.imem_req = 1'b1;
        for (int i = 0; i < iw; i++) push(1'b0, 1'b0, op, 1'b0, o);
        o.ir_we = 1'b1;
        push(1'b1, 1'b0, op, 1'b0, o);
        push(1'b0, 1'b0, op, 1'b0, blank(3'd1));
    endtask

    task automatic push_halt(input logic [6:0] op, input int n);
        obs_t o;
        o = blank(3'd5);
        o.trap = 1'b1;
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, op, 1'b1, o);
    endtask

    // Expected cycle-by-cycle trace of one legal instruction
    task automatic push_instr(input logic [6:0] op, input logic br, input int iw,
                              input int dw, input bit mem_abort);
        obs_t o;
        push_fetch(op, iw);
        o = blank(3'd2);
        o.alu_out_we = 1'b1;
        case (op)
            OP_I, OP_JALR, OP_LOAD, OP_STORE: o.b_sel = 1'b1;
            OP_AUIPC: begin o.a_sel = 1'b1; o.b_sel = 1'b1; end
            OP_BRANCH: begin o.pc_we = 1'b1; o.pc_sel = {1'b0, br}; o.instret = 1'b1; end
            default: ;
        endcase
        push(1'b0, 1'b0, op, br, o);
        if (op == OP_BRANCH) return;
        if (op == OP_LOAD || op == OP_STORE) begin
            o = blank(3'd3);
            o.dmem_req = 1'b1;
            o.dmem_we  = (op == OP_STORE);
            for (int i = 0; i < dw; i++) push(1'b0, 1'b0, op, br, o);
            if (mem_abort) return;
            if (op == OP_STORE) begin o.pc_we = 1'b1; o.instret = 1'b1; end
            push(1'b0, 1'b1, op, br, o);
            if (op == OP_STORE) return;
        end
        o = blank(3'd4);
        o.rf_we = 1'b1; o.pc_we = 1'b1; o.instret = 1'b1;
        o.wb_sel = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 :
                   (op == OP_LUI) ? 2'd3 : 2'd0;
        o.pc_sel = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
        push(1'b0, 1'b0, op, br, o);
    endtask

    task automatic drain(input string name, input bit which);
        cyc_t c;
        obs_t got;
        int   n = 0;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            mif.imem_ready = c.im;  mif_t.imem_ready = c.im;
            mif.dmem_ready = c.dm;  mif_t.dmem_ready = c.dm;
            opcode = c.op;
            br_taken = c.br;
            #1;
            got = get_obs(which);
            checks++;
            if (got !== c.exp) begin
                errors++;
                $display("FAIL %s cycle %0d got %h expected %h", name, n, got, c.exp);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string name);
        logic [7:0] sv, sv_t;
        @(negedge clk);
        rst = 1'b1;
        mif.imem_ready = 1'b0; mif_t.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0; mif_t.dmem_ready = 1'b0;
        #1;
        sv   = {mif.imem_req, mif.dmem_req, mif.dmem_we, ir_we, alu_out_we, pc_we, rf_we, instret};
        sv_t = {mif_t.imem_req, mif_t.dmem_req, mif_t.dmem_we, ir_we_t, alu_out_we_t,
                pc_we_t, rf_we_t, instret_t};
        checks++;
        if ({sv, sv_t} !== 16'h0) begin
            errors++;
            $display("FAIL %s strobes_in_rst got %h expected 0000", name, {sv, sv_t});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({state, trap, mif.imem_req, mif.dmem_req} !== 6'b000_0_1_0 ||
            {state_t, trap_t, mif_t.imem_req, mif_t.dmem_req} !== 6'b000_0_1_0) begin
            errors++;
            $display("FAIL %s after_rst got st=%0d trap=%b ireq=%b dreq=%b / st=%0d trap=%b expected st=0 trap=0 ireq=1 dreq=0",
                     name, state, trap, mif.imem_req, mif.dmem_req, state_t, trap_t);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_alu();
        push_instr(OP_I, 1'b0, 0, 0, 1'b0);
        push_instr(OP_R, 1'b0, 1, 0, 1'b0);
        push_instr(OP_AUIPC, 1'b0, 0, 0, 1'b0);
        drain("alu", 1'b0);
    endtask

    task automatic test_branch();
        push_instr(OP_BRANCH, 1'b1, 0, 0, 1'b0);
        push_instr(OP_BRANCH, 1'b0, 0, 0, 1'b0);
        drain("branch", 1'b0);
    endtask

    task automatic test_load();
        push_instr(OP_LOAD, 1'b0, 0, 3, 1'b0);
        drain("load", 1'b0);
    endtask

    task automatic test_store();
        push_instr(OP_STORE, 1'b0, 0, 0, 1'b0);
        push_instr(OP_STORE, 1'b1, 2, 2, 1'b0);
        drain("store", 1'b0);
    endtask

    task automatic test_jumps();
        push_instr(OP_JALR, 1'b0, 0, 0, 1'b0);
        push_instr(OP_JAL, 1'b0, 0, 0, 1'b0);
        push_instr(OP_LUI, 1'b0, 0, 0, 1'b0);
        drain("jumps", 1'b0);
    endtask

    // Ready arriving exactly at the timeout limit must still advance normally
    task automatic test_back_to_back();
        push_instr(OP_I, 1'b0, T_LIMIT, 0, 1'b0);
        push_instr(OP_LOAD, 1'b0, 0, T_LIMIT, 1'b0);
        push_instr(OP_BRANCH, 1'b1, 1, 0, 1'b0);
        push_instr(OP_STORE, 1'b0, 0, 1, 1'b0);
        push_instr(OP_JAL, 1'b0, 0, 0, 1'b0);
        drain("back_to_back", 1'b1);
    endtask

    task automatic test_reset_mid_mem();
        push_instr(OP_LOAD, 1'b0, 0, 2, 1'b1);
        drain("mid_mem_pre", 1'b0);
        do_reset("mid_mem_rst");
    endtask

    task automatic test_illegal();
        push_fetch(7'b0000000, 0);
        push_halt(7'b0000000, 20);
        drain("illegal_zero", 1'b0);
        do_reset("illegal_zero_rst");
        push_fetch(7'b1111111, 1);
        push_halt(7'b1111111, 3);
        drain("illegal_ones", 1'b0);
        do_reset("illegal_ones_rst");
    endtask

    task automatic test_timeout();
        obs_t o;
        o = blank(3'd0);
        o.imem_req = 1'b1;
        for (int i = 0; i <= T_LIMIT; i++) push(1'b0, 1'b0, OP_I, 1'b0, o);
        push_halt(OP_I, 4);
        drain("fetch_timeout", 1'b1);
        do_reset("fetch_timeout_rst");
        push_instr(OP_LOAD, 1'b0, 0, T_LIMIT + 1, 1'b1);
        push_halt(OP_LOAD, 4);
        drain("mem_timeout", 1'b1);
        do_reset("mem_timeout_rst");
    endtask

    initial begin
        rst = 1'b1;
        opcode = 7'd0;
        funct3 = 3'd0;
        br_taken = 1'b0;
        mif.imem_ready = 1'b0; mif_t.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0; mif_t.dmem_ready = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store();
        test_jumps();
        test_back_to_back();
        test_reset_mid_mem();
        test_illegal();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
